// File: rtl/neuron_layer_sequencer_if.sv
// Bundles the controller-side start/config/stall inputs and the buffer-swapper
// side address/strobe outputs of the neuron layer sequencer.
interface neuron_layer_sequencer_if #(
    parameter int A  = 11,
    parameter int DW = 8,
    parameter int PW = 4
);
    logic          start;
    logic [A-1:0]  cfgInBase;
    logic [A-1:0]  cfgOutBase;
    logic [DW-1:0] cfgRows;
    logic [DW-1:0] cfgCols;
    logic [PW-1:0] cfgPasses;
    logic          cfgPool;
    logic          stall;

    logic          busy;
    logic          done;
    logic          readBufferSelect;
    logic [A-1:0]  nReadAddress;
    logic          readValid;
    logic [A-1:0]  nWriteAddress;
    logic          nWWrite;
    logic          doPooling;

    modport master (
        output start, cfgInBase, cfgOutBase, cfgRows, cfgCols, cfgPasses, cfgPool, stall,
        input  busy, done, readBufferSelect, nReadAddress, readValid,
               nWriteAddress, nWWrite, doPooling
    );

    modport slave (
        input  start, cfgInBase, cfgOutBase, cfgRows, cfgCols, cfgPasses, cfgPool, stall,
        output busy, done, readBufferSelect, nReadAddress, readValid,
               nWriteAddress, nWWrite, doPooling
    );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Sequences one convolution layer: streams read addresses, emits write addresses
// delayed by the conv/pool pipeline latency, then flips the ping-pong buffer select.
module neuron_layer_sequencer #(
    parameter int A   = 11,
    parameter int LAT = 4,
    parameter int DW  = 8,
    parameter int PW  = 4
) (
    input logic                     CLK,
    input logic                     RSTn,
    neuron_layer_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, SWAP, DONE} state_t;

    localparam logic [A-1:0]  ONE_A    = 1;
    localparam logic [DW-1:0] ONE_DW   = 1;
    localparam logic [PW-1:0] ONE_PW   = 1;
    localparam logic [3:0]    LAT_LAST = 4'(LAT - 1);

    state_t        state, state_nx;

    logic [A-1:0]  in_base, out_base;
    logic [DW-1:0] rows, cols;
    logic [PW-1:0] passes;
    logic          pool;

    logic [DW-1:0] row_cnt, col_cnt;
    logic [PW-1:0] pass_cnt;
    logic [A-1:0]  idx;
    logic [A-1:0]  pool_base;
    logic [3:0]    drain_cnt;
    logic          rd_sel;

    logic [LAT-1:0] wr_vld_p;
    logic [A-1:0]   wr_addr_p [LAT];

    logic          last_col, last_row, last_pass;
    logic          final_pool, advance, shift_en, cfg_zero;
    logic          elem_vld;
    logic [A-1:0]  elem_addr;

    // Element address is a linear index off the base, so no multiplier is needed;
    // pooled writes use a separate row base that steps by cols/2 after each odd row.
    always_comb begin
        last_col   = (col_cnt == cols - ONE_DW);
        last_row   = (row_cnt == rows - ONE_DW);
        last_pass  = (pass_cnt == passes - ONE_PW);
        final_pool = pool && last_pass;
        advance    = (state == READ) && !bus.stall;
        shift_en   = ((state == READ) || (state == DRAIN)) && !bus.stall;
        cfg_zero   = (bus.cfgRows == '0) || (bus.cfgCols == '0) || (bus.cfgPasses == '0);
        elem_vld   = final_pool ? (row_cnt[0] && col_cnt[0]) : 1'b1;
        elem_addr  = final_pool ? (pool_base + A'(col_cnt >> 1)) : (out_base + idx);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx             = state;
        bus.busy             = 1'b0;
        bus.done             = 1'b0;
        bus.readValid        = 1'b0;
        bus.nReadAddress     = '0;
        bus.doPooling        = 1'b0;
        bus.nWWrite          = wr_vld_p[LAT-1] && !bus.stall;
        bus.nWriteAddress    = wr_addr_p[LAT-1];
        bus.readBufferSelect = rd_sel;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = cfg_zero ? DONE : READ;
            end
            READ: begin
                bus.busy         = 1'b1;
                bus.readValid    = !bus.stall;
                bus.nReadAddress = in_base + idx;
                bus.doPooling    = final_pool;
                if (advance && last_col && last_row && last_pass) state_nx = DRAIN;
            end
            DRAIN: begin
                bus.busy      = 1'b1;
                bus.doPooling = pool;
                if (!bus.stall && (drain_cnt == LAT_LAST)) state_nx = SWAP;
            end
            SWAP: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            in_base   <= '0;
            out_base  <= '0;
            rows      <= '0;
            cols      <= '0;
            passes    <= '0;
            pool      <= 1'b0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            pass_cnt  <= '0;
            idx       <= '0;
            pool_base <= '0;
            drain_cnt <= '0;
            rd_sel    <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                in_base   <= bus.cfgInBase;
                out_base  <= bus.cfgOutBase;
                rows      <= bus.cfgRows;
                cols      <= bus.cfgCols;
                passes    <= bus.cfgPasses;
                pool      <= bus.cfgPool;
                row_cnt   <= '0;
                col_cnt   <= '0;
                pass_cnt  <= '0;
                idx       <= '0;
                pool_base <= bus.cfgOutBase;
            end else if (advance) begin
                if (last_col) begin
                    col_cnt <= '0;
                    if (last_row) begin
                        row_cnt   <= '0;
                        idx       <= '0;
                        pool_base <= out_base;
                        pass_cnt  <= pass_cnt + ONE_PW;
                    end else begin
                        row_cnt <= row_cnt + ONE_DW;
                        idx     <= idx + ONE_A;
                        if (row_cnt[0]) pool_base <= pool_base + A'(cols >> 1);
                    end
                end else begin
                    col_cnt <= col_cnt + ONE_DW;
                    idx     <= idx + ONE_A;
                end
            end

            if (state != DRAIN) begin
                drain_cnt <= '0;
            end else if (!bus.stall) begin
                drain_cnt <= drain_cnt + 4'd1;
            end

            if (state == SWAP) rd_sel <= ~rd_sel;
        end
    end

    // Write pipeline: stage LAT-1 lines up with the conv/pool result of the read
    // issued LAT advancing cycles earlier; DRAIN shifts bubbles in to empty it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_vld_p <= '0;
            for (int i = 0; i < LAT; i++) wr_addr_p[i] <= '0;
        end else if (shift_en) begin
            wr_vld_p[0]  <= (state == READ) && elem_vld;
            wr_addr_p[0] <= (state == READ) ? elem_addr : '0;
            for (int i = 1; i < LAT; i++) begin
                wr_vld_p[i]  <= wr_vld_p[i-1];
                wr_addr_p[i] <= wr_addr_p[i-1];
            end
        end
    end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Scoreboard bench for neuron_layer_sequencer: expected read/write streams are queued
// as each layer is started and a negedge monitor pops and compares them.
module tb_neuron_layer_sequencer;
    localparam int A = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_layer_sequencer_if #(.A(A), .DW(8), .PW(4)) bus ();

    neuron_layer_sequencer #(.A(A), .LAT(4), .DW(8), .PW(4)) dut (
        .CLK (clk),
        .RSTn(rst_n),
        .bus (bus.slave)
    );

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [A:0] exp_rd[$];   // {doPooling, nReadAddress}
    logic [A-1:0] exp_wr[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic push_chk(input string n, input int a, input int e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    // Monitor: sole owner of the counters.
    always @(negedge clk) begin
        chk_t c;
        logic [A:0]   er;
        logic [A-1:0] ew;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            vectors++;
            if (c.act != c.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", c.name, c.act, c.act, c.exp, c.exp);
            end
        end
        if (bus.readValid) begin
            vectors++;
            if (exp_rd.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: got addr 0x%0h, expected no read", bus.nReadAddress);
            end else begin
                er = exp_rd.pop_front();
                if ({bus.doPooling, bus.nReadAddress} != er) begin
                    miscompares++;
                    $display("FAIL read: got pool=%0b addr=0x%0h, expected pool=%0b addr=0x%0h",
                             bus.doPooling, bus.nReadAddress, er[A], er[A-1:0]);
                end
            end
        end
        if (bus.nWWrite) begin
            vectors++;
            if (exp_wr.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr 0x%0h, expected no write", bus.nWriteAddress);
            end else begin
                ew = exp_wr.pop_front();
                if (bus.nWriteAddress != ew) begin
                    miscompares++;
                    $display("FAIL write: got addr 0x%0h, expected 0x%0h", bus.nWriteAddress, ew);
                end
            end
        end
        if (bus.stall) begin
            vectors++;
            if (bus.nWWrite) begin
                miscompares++;
                $display("FAIL write_during_stall: got nWWrite=1, expected 0");
            end
        end
    end

    task automatic start_layer(input logic [A-1:0] ib, input logic [A-1:0] ob,
                               input int r, input int c, input int p, input logic pl);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.cfgInBase  = ib;
        bus.cfgOutBase = ob;
        bus.cfgRows    = 8'(r);
        bus.cfgCols    = 8'(c);
        bus.cfgPasses  = 4'(p);
        bus.cfgPool    = pl;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        // Scribble the config lines to show only the latched copy matters.
        bus.cfgInBase  = 11'h555;
        bus.cfgOutBase = 11'h2AA;
        bus.cfgRows    = 8'd9;
        bus.cfgCols    = 8'd0;
        bus.cfgPasses  = 4'd3;
        bus.cfgPool    = ~pl;
    endtask

    // Cycle k=0 is the first cycle after the start edge; returns at the done cycle.
    task automatic run_layer(input int budget, output int rd0, output int wr0, output int wrl,
                             output int dn, output int busy_n, output int rd_n, output int wr_n);
        rd0 = -1; wr0 = -1; wrl = -1; dn = -1; busy_n = 0; rd_n = 0; wr_n = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.readValid) begin
                rd_n++;
                if (rd0 < 0) rd0 = k;
            end
            if (bus.nWWrite) begin
                wr_n++;
                wrl = k;
                if (wr0 < 0) wr0 = k;
            end
            if (bus.done) begin
                dn = k;
                break;
            end
        end
        if (dn < 0) push_chk("done_timeout", 0, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        push_chk({tag, "_busy"}, int'(bus.busy), 0);
        push_chk({tag, "_done"}, int'(bus.done), 0);
        push_chk({tag, "_rbs"}, int'(bus.readBufferSelect), 0);
        push_chk({tag, "_readValid"}, int'(bus.readValid), 0);
        push_chk({tag, "_nWWrite"}, int'(bus.nWWrite), 0);
        push_chk({tag, "_doPooling"}, int'(bus.doPooling), 0);
        push_chk({tag, "_nReadAddress"}, int'(bus.nReadAddress), 0);
        push_chk({tag, "_nWriteAddress"}, int'(bus.nWriteAddress), 0);
    endtask

    initial begin
        int rd0, wr0, wrl, dn, bn, rn, wn, cnt;
        bus.start = 1'b0; bus.stall = 1'b0;
        bus.cfgInBase = '0; bus.cfgOutBase = '0; bus.cfgRows = '0;
        bus.cfgCols = '0; bus.cfgPasses = '0; bus.cfgPool = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic 2x3 layer
        for (int i = 0; i < 6; i++) begin
            exp_rd.push_back({1'b0, 11'(11'h010 + i)});
            exp_wr.push_back(11'(11'h200 + i));
        end
        start_layer(11'h010, 11'h200, 2, 3, 1, 1'b0);
        run_layer(60, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("basic_first_read", rd0, 0);
        push_chk("basic_first_write", wr0, 4);
        push_chk("basic_last_write", wrl, 9);
        push_chk("basic_done", dn, 11);
        push_chk("basic_busy_cycles", bn, 11);
        push_chk("basic_reads", rn, 6);
        push_chk("basic_writes", wn, 6);
        push_chk("basic_rbs", int'(bus.readBufferSelect), 1);

        // Asynchronous reset after 5 reads of a 4x4 layer
        for (int i = 0; i < 5; i++) exp_rd.push_back({1'b0, 11'(11'h080 + i)});
        exp_wr.push_back(11'h180);
        start_layer(11'h080, 11'h180, 4, 4, 1, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.nWWrite || bus.busy) cnt++;
        end
        push_chk("midreset_quiet_after_release", cnt, 0);

        // 4x4 pooling layer, 2 passes
        for (int i = 0; i < 16; i++) begin
            exp_rd.push_back({1'b0, 11'(11'h040 + i)});
            exp_wr.push_back(11'(11'h100 + i));
        end
        for (int i = 0; i < 16; i++) exp_rd.push_back({1'b1, 11'(11'h040 + i)});
        for (int i = 0; i < 4; i++) exp_wr.push_back(11'(11'h100 + i));
        start_layer(11'h040, 11'h100, 4, 4, 2, 1'b1);
        run_layer(100, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("pool_first_write", wr0, 4);
        push_chk("pool_last_write", wrl, 35);
        push_chk("pool_done", dn, 37);
        push_chk("pool_reads", rn, 32);
        push_chk("pool_writes", wn, 20);
        push_chk("pool_rbs", int'(bus.readBufferSelect), 1);

        // Basic layer again with a 3-cycle stall while the first write is due
        for (int i = 0; i < 6; i++) begin
            exp_rd.push_back({1'b0, 11'(11'h010 + i)});
            exp_wr.push_back(11'(11'h200 + i));
        end
        start_layer(11'h010, 11'h200, 2, 3, 1, 1'b0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.stall = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                bus.stall = 1'b0;
            end
            run_layer(60, rd0, wr0, wrl, dn, bn, rn, wn);
        join
        push_chk("stall_first_write", wr0, 7);
        push_chk("stall_last_write", wrl, 12);
        push_chk("stall_done", dn, 14);
        push_chk("stall_busy_cycles", bn, 14);
        push_chk("stall_reads", rn, 6);
        push_chk("stall_writes", wn, 6);
        push_chk("stall_rbs", int'(bus.readBufferSelect), 0);

        // cols=0: straight to DONE
        start_layer(11'h010, 11'h200, 2, 0, 1, 1'b0);
        run_layer(20, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("degen_done", dn, 0);
        push_chk("degen_busy_cycles", bn, 0);
        push_chk("degen_reads", rn, 0);
        push_chk("degen_writes", wn, 0);
        push_chk("degen_rbs", int'(bus.readBufferSelect), 0);

        // start while busy is ignored
        exp_rd.push_back({1'b0, 11'h020});
        exp_rd.push_back({1'b0, 11'h021});
        exp_wr.push_back(11'h300);
        exp_wr.push_back(11'h301);
        start_layer(11'h020, 11'h300, 1, 2, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.cfgCols = 8'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        run_layer(40, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("ignore_done", dn, 5);
        push_chk("ignore_writes", wn, 2);
        push_chk("ignore_rbs", int'(bus.readBufferSelect), 1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.busy || bus.readValid) cnt++;
        end
        push_chk("ignore_no_second_layer", cnt, 0);

        // Address wrap, then a back-to-back layer started right after done
        exp_rd.push_back({1'b0, 11'h7FE});
        exp_rd.push_back({1'b0, 11'h7FF});
        exp_rd.push_back({1'b0, 11'h000});
        exp_rd.push_back({1'b0, 11'h001});
        exp_wr.push_back(11'h7FD);
        exp_wr.push_back(11'h7FE);
        exp_wr.push_back(11'h7FF);
        exp_wr.push_back(11'h000);
        start_layer(11'h7FE, 11'h7FD, 1, 4, 1, 1'b0);
        run_layer(40, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("wrap_done", dn, 9);
        push_chk("wrap_reads", rn, 4);
        push_chk("wrap_rbs", int'(bus.readBufferSelect), 0);

        exp_rd.push_back({1'b0, 11'h005});
        exp_wr.push_back(11'h006);
        start_layer(11'h005, 11'h006, 1, 1, 1, 1'b0);
        run_layer(40, rd0, wr0, wrl, dn, bn, rn, wn);
        push_chk("b2b_first_read", rd0, 0);
        push_chk("b2b_first_write", wr0, 4);
        push_chk("b2b_done", dn, 6);
        push_chk("b2b_rbs", int'(bus.readBufferSelect), 1);

        repeat (2) @(negedge clk);
        push_chk("reads_outstanding", exp_rd.size(), 0);
        push_chk("writes_outstanding", exp_wr.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
